// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared types for the coherence bus controller.
//   bus_state_t                  - controller FSM state encoding
//   cache_coherence_statistics_t - per-bus event counters for observers
//   idx_width()                  - width of an index over n units (min 1)
package coherence_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARBITRATE,
        SNOOP,
        C2C,
        FLUSH,
        MEM_READ,
        MEM_WRITE,
        DONE
    } bus_state_t;

    typedef struct packed {
        logic [31:0] reads;
        logic [31:0] writebacks;
        logic [31:0] c2c_transfers;
        logic [31:0] flushes;
    } cache_coherence_statistics_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/coherence_bus_ctrl_rr_arbiter.sv
// Round-robin arbiter.
//   CLK, nRST  - clock, asynchronous active-low reset
//   req        - one request bit per unit
//   enable     - advance the pointer past the current winner
//   grant      - one-hot winner
//   grant_idx  - binary winner index
//   valid      - some request is present
// The search starts at the pointer, which sits one past the last winner.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic [N-1:0]  req,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          valid
);

    logic [IW-1:0] ptr;

    always_comb begin
        int cand;
        cand      = 0;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) cand = cand - N;
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant_idx   = IW'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr <= '0;
        end else if (enable && valid) begin
            ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Snooping coherence bus controller: arbitrates CPU read / read-for-ownership
// / writeback requests, snoops the other CPUs, performs cache-to-cache
// transfers (flushing dirty supplier lines) or memory reads/writes.
//   CLK, nRST                         - clock, asynchronous active-low reset
//   dREN, dWEN, ccwrite, daddr, dstore - per-CPU requests and data
//   ccsnoopdone, ccsnoophit, ccdirty   - per-CPU snoop responses
//   dwait, dload, ccwait, ccinv, ccexclusive, ccsnoopaddr - per-CPU replies
//   mem_ren, mem_wen, mem_addr, mem_wdata, mem_rdata, mem_busy - memory port
module coherence_bus_ctrl
    import coherence_pkg::*;
#(
    parameter int NCPUS      = 2,
    parameter int BLOCK_SIZE = 2,
    parameter int ADDR_WIDTH = 32,
    localparam int BW        = 32 * BLOCK_SIZE
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NCPUS-1:0]      dREN,
    input  logic [NCPUS-1:0]      dWEN,
    input  logic [NCPUS-1:0]      ccwrite,
    input  logic [ADDR_WIDTH-1:0] daddr [NCPUS],
    input  logic [BW-1:0]         dstore [NCPUS],
    input  logic [NCPUS-1:0]      ccsnoopdone,
    input  logic [NCPUS-1:0]      ccsnoophit,
    input  logic [NCPUS-1:0]      ccdirty,
    output logic [NCPUS-1:0]      dwait,
    output logic [BW-1:0]         dload [NCPUS],
    output logic [NCPUS-1:0]      ccwait,
    output logic [NCPUS-1:0]      ccinv,
    output logic [NCPUS-1:0]      ccexclusive,
    output logic [ADDR_WIDTH-1:0] ccsnoopaddr [NCPUS],
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BW-1:0]         mem_wdata,
    input  logic [BW-1:0]         mem_rdata,
    input  logic                  mem_busy
);

    localparam int IW = idx_width(NCPUS);

    bus_state_t state, state_next;

    logic [IW-1:0]         gidx;
    logic [ADDR_WIDTH-1:0] addr_lat;
    logic                  ccwrite_lat;
    logic [BW-1:0]         data_lat;
    logic [IW-1:0]         sup_idx;
    logic [BW-1:0]         line_lat;
    logic [BW-1:0]         dload_reg [NCPUS];
    logic [NCPUS-1:0]      excl_reg;

    logic [NCPUS-1:0]      arb_grant;
    logic [IW-1:0]         arb_idx;
    logic                  arb_valid;
    logic                  arb_is_wb;
    logic [NCPUS-1:0]      grant_mask;
    logic [NCPUS-1:0]      hits;
    logic                  all_done;
    logic [IW-1:0]         hit_idx;

    rr_arbiter #(.N(NCPUS), .IW(IW)) u_arb (
        .CLK       (CLK),
        .nRST      (nRST),
        .req       (dREN | dWEN),
        .enable    (state == ARBITRATE),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    // A writeback wins over a read if a CPU raises both.
    assign arb_is_wb = |(arb_grant & dWEN);

    always_comb begin
        grant_mask       = '0;
        grant_mask[gidx] = 1'b1;
    end

    // The requester never answers its own snoop.
    assign hits     = ccsnoophit & ~grant_mask;
    assign all_done = &(ccsnoopdone | grant_mask);

    // Descending scan so the lowest-index hitter is left as supplier.
    always_comb begin
        hit_idx = '0;
        for (int j = NCPUS - 1; j >= 0; j--) begin
            if (hits[j]) hit_idx = IW'(j);
        end
    end

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (|(dREN | dWEN)) state_next = ARBITRATE;
            ARBITRATE: begin
                if (!arb_valid)     state_next = IDLE;
                else if (arb_is_wb) state_next = MEM_WRITE;
                else                state_next = SNOOP;
            end
            SNOOP:     if (all_done) state_next = (|hits) ? C2C : MEM_READ;
            C2C:       state_next = ccdirty[sup_idx] ? FLUSH : DONE;
            FLUSH:     if (!mem_busy) state_next = DONE;
            MEM_READ:  if (!mem_busy) state_next = DONE;
            MEM_WRITE: if (!mem_busy) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Transaction datapath
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            gidx        <= '0;
            addr_lat    <= '0;
            ccwrite_lat <= 1'b0;
            data_lat    <= '0;
            sup_idx     <= '0;
            line_lat    <= '0;
            excl_reg    <= '0;
            for (int j = 0; j < NCPUS; j++) dload_reg[j] <= '0;
        end else begin
            if (state == ARBITRATE && arb_valid) begin
                gidx        <= arb_idx;
                addr_lat    <= daddr[arb_idx];
                ccwrite_lat <= ccwrite[arb_idx];
                data_lat    <= dstore[arb_idx];
            end
            if (state == SNOOP && all_done && |hits) sup_idx <= hit_idx;
            if (state == C2C) begin
                dload_reg[gidx] <= dstore[sup_idx];
                line_lat        <= dstore[sup_idx];
                excl_reg[gidx]  <= 1'b0;
            end
            if (state == MEM_READ && !mem_busy) begin
                dload_reg[gidx] <= mem_rdata;
                excl_reg[gidx]  <= 1'b1;
            end
        end
    end

    // Output logic
    always_comb begin
        dwait = '1;
        if (state == DONE) dwait[gidx] = 1'b0;
        ccwait = '0;
        if (state == SNOOP || state == C2C || state == FLUSH) ccwait = ~grant_mask;
        ccinv     = ccwait & {NCPUS{ccwrite_lat}};
        mem_ren   = (state == MEM_READ);
        mem_wen   = (state == FLUSH) || (state == MEM_WRITE);
        mem_addr  = addr_lat;
        mem_wdata = (state == FLUSH) ? line_lat : data_lat;
    end

    assign ccexclusive = excl_reg;

    for (genvar gi = 0; gi < NCPUS; gi++) begin : g_cpu
        assign dload[gi]       = dload_reg[gi];
        assign ccsnoopaddr[gi] = addr_lat;
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
module tb_coherence_bus_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  dREN, dWEN, ccwrite;
    logic [31:0] daddr [2];
    logic [63:0] dstore [2];
    logic [1:0]  ccsnoopdone, ccsnoophit, ccdirty;
    logic [1:0]  dwait;
    logic [63:0] dload [2];
    logic [1:0]  ccwait, ccinv, ccexclusive;
    logic [31:0] ccsnoopaddr [2];
    logic        mem_ren, mem_wen;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic        mem_busy;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    coherence_bus_ctrl #(.NCPUS(2), .BLOCK_SIZE(2), .ADDR_WIDTH(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .dREN(dREN), .dWEN(dWEN), .ccwrite(ccwrite),
        .daddr(daddr), .dstore(dstore),
        .ccsnoopdone(ccsnoopdone), .ccsnoophit(ccsnoophit), .ccdirty(ccdirty),
        .dwait(dwait), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccexclusive(ccexclusive),
        .ccsnoopaddr(ccsnoopaddr),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_busy(mem_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        int          cpu;
        logic        rd, wb, ccw;
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  hit, dirty;
        logic [63:0] sup, rdata;
        int          busy;
        logic [63:0] e_dload;
        logic        e_excl;
        int          e_ren, e_wen;
        logic [31:0] e_waddr;
        logic [63:0] e_wdata;
        logic        e_inv, e_snoop;
        int          e_lat;
    } vec_t;

    vec_t vecs [6];

    // Runs one single-requester transaction and checks what it produced.
    task automatic run_vec(input int n);
        vec_t v;
        int other, lat, ren_cnt, wen_cnt, busy_left;
        logic inv_seen, snoop_seen, other_low, done;
        logic [31:0] waddr;
        logic [63:0] wdata;
        v = vecs[n];
        other = 1 - v.cpu;
        lat = 1; ren_cnt = 0; wen_cnt = 0; busy_left = v.busy;
        inv_seen = 0; snoop_seen = 0; other_low = 0; done = 0;
        waddr = '0; wdata = '0;
        @(negedge CLK);
        daddr[v.cpu]  = v.addr;
        dstore[v.cpu] = v.data;
        dstore[other] = v.sup;
        ccsnoopdone = 2'b11;
        ccsnoophit  = v.hit;
        ccdirty     = v.dirty;
        mem_rdata   = v.rdata;
        mem_busy    = 1'b0;
        dREN[v.cpu]    = v.rd;
        dWEN[v.cpu]    = v.wb;
        ccwrite[v.cpu] = v.ccw;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            lat++;
            if (mem_ren) ren_cnt++;
            if (mem_wen) begin
                wen_cnt++;
                waddr = mem_addr;
                wdata = mem_wdata;
            end
            if (ccinv[other])  inv_seen = 1;
            if (ccwait[other]) snoop_seen = 1;
            if (!dwait[other]) other_low = 1;
            if ((mem_ren || mem_wen) && busy_left > 0) begin
                mem_busy = 1'b1;
                busy_left--;
            end else begin
                mem_busy = 1'b0;
            end
            if (!dwait[v.cpu]) done = 1;
        end
        dREN = 2'b00; dWEN = 2'b00; ccwrite = 2'b00; mem_busy = 1'b0;
        chk($sformatf("v%0d_done", n), 64'(done), 64'd1);
        chk($sformatf("v%0d_latency", n), 64'(lat), 64'(v.e_lat));
        chk($sformatf("v%0d_ren_cycles", n), 64'(ren_cnt), 64'(v.e_ren));
        chk($sformatf("v%0d_wen_cycles", n), 64'(wen_cnt), 64'(v.e_wen));
        if (v.e_wen > 0) begin
            chk($sformatf("v%0d_mem_addr", n), 64'(waddr), 64'(v.e_waddr));
            chk($sformatf("v%0d_mem_wdata", n), wdata, v.e_wdata);
        end
        chk($sformatf("v%0d_ccinv", n), 64'(inv_seen), 64'(v.e_inv));
        chk($sformatf("v%0d_ccwait", n), 64'(snoop_seen), 64'(v.e_snoop));
        chk($sformatf("v%0d_other_dwait", n), 64'(other_low), 64'd0);
        @(negedge CLK);
        chk($sformatf("v%0d_dwait_one_cycle", n), 64'(dwait), 64'b11);
        chk($sformatf("v%0d_dload", n), dload[v.cpu], v.e_dload);
        chk($sformatf("v%0d_ccexclusive", n), 64'(ccexclusive[v.cpu]), 64'(v.e_excl));
        $display("txn %0d cpu=%0d addr=%h lat=%0d ren=%0d wen=%0d dload=%h excl=%0d",
                 n, v.cpu, v.addr, lat, ren_cnt, wen_cnt, dload[v.cpu], ccexclusive[v.cpu]);
    endtask

    // Waits for some CPU's dwait to drop; who=-1 on timeout.
    task automatic wait_done(output int who);
        who = -1;
        for (int c = 0; c < 30 && who < 0; c++) begin
            @(negedge CLK);
            if (!dwait[0])      who = 0;
            else if (!dwait[1]) who = 1;
        end
    endtask

    initial begin
        int who, cnt;
        logic seen;
        nRST = 1'b0;
        dREN = 0; dWEN = 0; ccwrite = 0;
        daddr[0] = 0; daddr[1] = 0; dstore[0] = 0; dstore[1] = 0;
        ccsnoopdone = 0; ccsnoophit = 0; ccdirty = 0;
        mem_rdata = 0; mem_busy = 0;

        //        cpu rd wb ccw addr         data          hit    dirty  sup           rdata                   busy
        //        e_dload                 excl ren wen waddr         e_wdata       inv snp lat
        vecs[0] = '{0, 1, 0, 0, 32'h100, 64'h0,    2'b00, 2'b00, 64'h0,    64'hAAAA_BBBB, 0,
                    64'hAAAA_BBBB,          1, 1, 0, 32'h0,   64'h0,    0, 1, 5};
        vecs[1] = '{1, 1, 0, 0, 32'h200, 64'h0,    2'b01, 2'b01, 64'h1234, 64'hDEAD, 0,
                    64'h1234,               0, 0, 1, 32'h200, 64'h1234, 0, 1, 6};
        vecs[2] = '{0, 1, 0, 1, 32'h300, 64'h0,    2'b10, 2'b00, 64'h5555, 64'hDEAD, 0,
                    64'h5555,               0, 0, 0, 32'h0,   64'h0,    1, 1, 5};
        vecs[3] = '{1, 0, 1, 0, 32'h400, 64'hCAFE, 2'b00, 2'b00, 64'h0,    64'hDEAD, 3,
                    64'h1234,               0, 0, 4, 32'h400, 64'hCAFE, 0, 0, 7};
        vecs[4] = '{0, 0, 1, 0, 32'h500, 64'hBEEF, 2'b00, 2'b00, 64'h0,    64'hDEAD, 0,
                    64'h5555,               0, 0, 1, 32'h500, 64'hBEEF, 0, 0, 4};
        vecs[5] = '{0, 1, 0, 0, 32'h600, 64'h0,    2'b00, 2'b00, 64'h0,    64'h1111_2222_3333_4444, 2,
                    64'h1111_2222_3333_4444, 1, 3, 0, 32'h0,  64'h0,    0, 1, 7};

        repeat (2) @(negedge CLK);
        chk("rst_dwait", 64'(dwait), 64'b11);
        chk("rst_ccwait", 64'(ccwait), 64'b00);
        chk("rst_ccinv", 64'(ccinv), 64'b00);
        chk("rst_ccexclusive", 64'(ccexclusive), 64'b00);
        chk("rst_mem_req", 64'({mem_ren, mem_wen}), 64'b00);
        chk("rst_dload0", dload[0], 64'h0);
        chk("rst_dload1", dload[1], 64'h0);
        nRST = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i);

        // Reset while flushing a dirty supplier line.
        @(negedge CLK);
        daddr[1] = 32'h700; dstore[0] = 64'h9999;
        ccsnoopdone = 2'b11; ccsnoophit = 2'b01; ccdirty = 2'b01;
        mem_busy = 1'b1;
        dREN[1] = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge CLK);
            if (mem_wen) seen = 1;
        end
        chk("flush_reached", 64'(seen), 64'd1);
        nRST = 1'b0;
        dREN = 2'b00; ccsnoophit = 0; ccdirty = 0;
        @(negedge CLK);
        chk("flush_rst_mem_wen", 64'(mem_wen), 64'd0);
        chk("flush_rst_dwait", 64'(dwait), 64'b11);
        chk("flush_rst_ccwait", 64'(ccwait | ccinv), 64'b00);
        chk("flush_rst_excl", 64'(ccexclusive), 64'b00);
        chk("flush_rst_dload1", dload[1], 64'h0);
        mem_busy = 1'b0;
        nRST = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (mem_wen || mem_ren || dwait != 2'b11) cnt++;
        end
        chk("flush_rst_no_activity", 64'(cnt), 64'd0);
        $display("txn reset-in-flush activity_after=%0d", cnt);

        // Request withdrawn before it is granted.
        dREN[0] = 1'b1; daddr[0] = 32'h800; ccsnoopdone = 2'b11;
        @(negedge CLK);
        dREN[0] = 1'b0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (mem_wen || mem_ren || dwait != 2'b11) cnt++;
        end
        chk("dropped_req_ignored", 64'(cnt), 64'd0);
        $display("txn dropped-request activity=%0d", cnt);

        // Round-robin: pointer is 0 after reset.
        mem_rdata = 64'h77;
        dREN = 2'b11; daddr[0] = 32'hA00; daddr[1] = 32'hB00;
        wait_done(who);
        chk("rr_pair1_first", 64'(who), 64'd0);
        if (who >= 0) dREN[who] = 1'b0;
        wait_done(who);
        chk("rr_pair1_second", 64'(who), 64'd1);
        dREN = 2'b00;
        $display("txn rr pair1 served");
        @(negedge CLK);
        dREN = 2'b01;
        wait_done(who);
        chk("rr_single_cpu0", 64'(who), 64'd0);
        dREN = 2'b00;
        $display("txn rr single cpu0 served");
        @(negedge CLK);
        dREN = 2'b11;
        wait_done(who);
        chk("rr_pair2_first", 64'(who), 64'd1);
        if (who >= 0) dREN[who] = 1'b0;
        wait_done(who);
        chk("rr_pair2_second", 64'(who), 64'd0);
        dREN = 2'b00;
        $display("txn rr pair2 served");

        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
